// File: rtl/dsp48a1_pkg.sv
// Shared constants and state encoding for the DSP48A1 multiply-accumulate sequencer.
package dsp48a1_pkg;

    localparam logic [7:0] OP_M_ONLY   = 8'b0000_0001;
    localparam logic [7:0] OP_P_PLUS_M = 8'b0000_1001;
    localparam logic [7:0] OP_P_HOLD   = 8'b0000_1000;

    // Cycles between the last operand accept and P being final (OPMODE/M, P, capture).
    localparam int DRAIN_CYCLES = 3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/dsp48a1_mac_sequencer.sv
// Drives one DSP48A1 slice as a dot-product engine: streams operand pairs, issues
// pipeline-aligned OPMODE and captures the accumulated P as the job result.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accepting operand pairs, remaining count > 0
// DRAIN | last pair accepted, waiting for it to reach P
// DONE  | result valid for one cycle, a new start is accepted here
module dsp48a1_mac_sequencer
    import dsp48a1_pkg::*;
#(
    parameter int LEN_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [17:0]      in_a,
    input  logic [17:0]      in_b,
    output logic [17:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic [7:0]       dsp_opmode,
    output logic             dsp_rst,
    input  logic [47:0]      dsp_p,
    output logic [47:0]      result,
    output logic             result_valid,
    output logic             busy
);

    localparam logic [1:0] DRAIN_LOAD = 2'(DRAIN_CYCLES - 1);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             first_q, first_d;
    logic [1:0]       drain_q, drain_d;
    logic [7:0]       op_q, op_d;
    logic [47:0]      result_q, result_d;
    logic             result_valid_q, result_valid_d;
    logic             dsp_rst_q, dsp_rst_d;
    logic             accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            rem_q          <= '0;
            first_q        <= 1'b0;
            drain_q        <= '0;
            op_q           <= OP_P_HOLD;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            dsp_rst_q      <= 1'b1;
        end else begin
            state_q        <= state_d;
            rem_q          <= rem_d;
            first_q        <= first_d;
            drain_q        <= drain_d;
            op_q           <= op_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            dsp_rst_q      <= dsp_rst_d;
        end
    end

    assign in_ready = (state_q == RUN) && (rem_q != '0);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d        = state_q;
        rem_d          = rem_q;
        first_d        = first_q;
        drain_d        = drain_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        dsp_rst_d      = 1'b0;
        op_d           = OP_P_HOLD;

        // X=0 on bubbles masks whatever the M register holds.
        if (accept) begin
            op_d = first_q ? OP_M_ONLY : OP_P_PLUS_M;
        end

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    if (len == '0) begin
                        state_d        = DONE;
                        result_d       = '0;
                        result_valid_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        rem_d   = len;
                        first_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    first_d = 1'b0;
                    rem_d   = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = DRAIN;
                        drain_d = DRAIN_LOAD;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    state_d        = DONE;
                    result_d       = dsp_p;
                    result_valid_d = 1'b1;
                end else begin
                    drain_d = drain_q - 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy         = (state_q == RUN) || (state_q == DRAIN);
    assign dsp_a        = in_a;
    assign dsp_b        = in_b;
    assign dsp_opmode   = op_q;
    assign dsp_rst      = dsp_rst_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule
